// File: rtl/sa_job_scheduler_pkg.sv
// Shared types and constants for the systolic-array job scheduler.
package sa_job_scheduler_pkg;

  localparam int NUM_REQ = 2;

  // Encodings fixed so the state value is stable across builds and in waveforms.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_WAIT_CAL = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/sa_job_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: rr_ptr only breaks ties when both requesters are active.
module rr_arbiter2
  import sa_job_scheduler_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               rr_ptr,
  output logic [NUM_REQ-1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = rr_ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/sa_job_scheduler.sv
// Shares the systolic array between the EKF predict/update requesters and sequences each job tile by tile.
module sa_job_scheduler
  import sa_job_scheduler_pkg::*;
#(
  parameter int TW      = 8,
  parameter int DRAIN   = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                sys_rst,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [TW-1:0]       req_tiles_0,
  input  logic [TW-1:0]       req_tiles_1,
  output logic [NUM_REQ-1:0]  grant,
  output logic                busy,
  output logic [NUM_REQ-1:0]  done,
  output logic                job_err,
  output logic                sa_start,
  input  logic                sa_cal_done,
  output logic                out_drain_en,
  output logic [TW-1:0]       tile_idx
);

  localparam logic [9:0] WD_LIMIT   = 10'(TIMEOUT - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN - 1);

  state_t              state_reg, state_next;
  logic                rr_ptr_reg, rr_ptr_next;
  logic                owner_reg, owner_next;
  logic [TW-1:0]       count_reg, count_next;
  logic [TW-1:0]       tile_idx_reg, tile_idx_next;
  logic [9:0]          wd_reg, wd_next;
  logic [7:0]          drain_cnt_reg, drain_cnt_next;
  logic                err_reg, err_next;
  logic [NUM_REQ-1:0]  grant_reg, grant_next;
  logic                busy_reg, busy_next;
  logic [NUM_REQ-1:0]  done_reg, done_next;
  logic                job_err_reg, job_err_next;
  logic                sa_start_reg, sa_start_next;
  logic                drain_en_reg, drain_en_next;
  logic [NUM_REQ-1:0]  gnt;

  rr_arbiter2 u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_reg),
    .gnt    (gnt)
  );

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    owner_next     = owner_reg;
    count_next     = count_reg;
    tile_idx_next  = tile_idx_reg;
    wd_next        = wd_reg;
    drain_cnt_next = drain_cnt_reg;
    err_next       = err_reg;
    grant_next     = grant_reg;
    busy_next      = busy_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|req) begin
          grant_next    = gnt;
          busy_next     = 1'b1;
          owner_next    = gnt[1];
          count_next    = gnt[1] ? req_tiles_1 : req_tiles_0;
          tile_idx_next = '0;
          err_next      = 1'b0;
          state_next    = (count_next != '0) ? ST_START : ST_DONE;
        end
      end
      ST_START: begin
        wd_next    = '0;
        state_next = ST_WAIT_CAL;
      end
      ST_WAIT_CAL: begin
        // A completion arriving in the expiry cycle takes priority over the abort.
        if (sa_cal_done) begin
          drain_cnt_next = '0;
          state_next     = ST_DRAIN;
        end else begin
          wd_next = wd_reg + 10'd1;
          if (wd_next >= WD_LIMIT) begin
            err_next   = 1'b1;
            state_next = ST_DONE;
          end
        end
      end
      ST_DRAIN: begin
        drain_cnt_next = drain_cnt_reg + 8'd1;
        if (drain_cnt_reg == DRAIN_LAST) begin
          if (tile_idx_reg == count_reg - TW'(1)) begin
            state_next = ST_DONE;
          end else begin
            tile_idx_next = tile_idx_reg + TW'(1);
            state_next    = ST_START;
          end
        end
      end
      ST_DONE: begin
        grant_next  = '0;
        busy_next   = 1'b0;
        rr_ptr_next = ~owner_reg;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Strobes are decoded from the next state so they register in step with it.
    sa_start_next = (state_next == ST_START);
    drain_en_next = (state_next == ST_DRAIN);
    done_next     = '0;
    if (state_next == ST_DONE) begin
      done_next[owner_next] = 1'b1;
    end
    job_err_next = (state_next == ST_DONE) && err_next;
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_reg     <= ST_IDLE;
      rr_ptr_reg    <= 1'b0;
      owner_reg     <= 1'b0;
      count_reg     <= '0;
      tile_idx_reg  <= '0;
      wd_reg        <= '0;
      drain_cnt_reg <= '0;
      err_reg       <= 1'b0;
      grant_reg     <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= '0;
      job_err_reg   <= 1'b0;
      sa_start_reg  <= 1'b0;
      drain_en_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      owner_reg     <= owner_next;
      count_reg     <= count_next;
      tile_idx_reg  <= tile_idx_next;
      wd_reg        <= wd_next;
      drain_cnt_reg <= drain_cnt_next;
      err_reg       <= err_next;
      grant_reg     <= grant_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      job_err_reg   <= job_err_next;
      sa_start_reg  <= sa_start_next;
      drain_en_reg  <= drain_en_next;
    end
  end

  assign grant        = grant_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign job_err      = job_err_reg;
  assign sa_start     = sa_start_reg;
  assign out_drain_en = drain_en_reg;
  assign tile_idx     = tile_idx_reg;

endmodule

// File: tb/tb_sa_job_scheduler.sv
// Directed bench for sa_job_scheduler: a responder models the SA completion pulse, a monitor logs events.
module tb_sa_job_scheduler;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [7:0] req_tiles_0 = 8'd0;
  logic [7:0] req_tiles_1 = 8'd0;
  logic [1:0] grant;
  logic       busy;
  logic [1:0] done;
  logic       job_err;
  logic       sa_start;
  logic       sa_cal_done;
  logic       out_drain_en;
  logic [7:0] tile_idx;

  logic cal_resp = 1'b0;
  logic cal_force = 1'b0;
  assign sa_cal_done = cal_resp | cal_force;

  sa_job_scheduler #(.TW(8), .DRAIN(3), .TIMEOUT(64)) dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .req          (req),
    .req_tiles_0  (req_tiles_0),
    .req_tiles_1  (req_tiles_1),
    .grant        (grant),
    .busy         (busy),
    .done         (done),
    .job_err      (job_err),
    .sa_start     (sa_start),
    .sa_cal_done  (sa_cal_done),
    .out_drain_en (out_drain_en),
    .tile_idx     (tile_idx)
  );

  int n_total = 0;
  int n_pass = 0;
  int cyc = 0;
  int cal_delay = 0;
  int cd = 0;
  int stray_en = 0;
  int n_start, n_drain, n_grant, n_done, last_start_cyc;
  int start_idx [8];
  int grant_hist [4];
  int grant_cyc [4];
  int done_hist [4];
  int err_hist [4];
  int done_cyc [4];
  int done_busy [4];
  logic [1:0] prev_grant;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SA model: completion pulse cal_delay cycles after each sa_start (0 = never), optional stray pulses in drain.
  initial forever begin
    @(negedge clk);
    cal_resp = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) cal_resp = 1'b1;
    end
    if (sa_start && cal_delay > 0) cd = cal_delay;
    if (stray_en != 0 && out_drain_en) cal_resp = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (sa_start) begin
      if (n_start < 8) start_idx[n_start] = int'(tile_idx);
      n_start++;
      last_start_cyc = cyc;
    end
    if (out_drain_en) n_drain++;
    if (grant != 2'b00 && prev_grant == 2'b00) begin
      if (n_grant < 4) begin
        grant_hist[n_grant] = int'(grant);
        grant_cyc[n_grant]  = cyc;
      end
      n_grant++;
    end
    prev_grant = grant;
    if (done != 2'b00) begin
      if (n_done < 4) begin
        done_hist[n_done] = int'(done);
        err_hist[n_done]  = int'(job_err);
        done_cyc[n_done]  = cyc;
        done_busy[n_done] = int'(busy);
      end
      n_done++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic clear_log();
    n_start = 0; n_drain = 0; n_grant = 0; n_done = 0;
    last_start_cyc = 0; prev_grant = 2'b00; cd = 0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && n_done < target; i++) step();
    chk(tag, n_done, target);
  endtask

  function automatic int outs();
    return int'({grant, busy, done, job_err, sa_start, out_drain_en, tile_idx});
  endfunction

  int rc;
  int found;

  initial begin
    clear_log();
    // 1: reset with random inputs
    for (int i = 0; i < 3; i++) begin
      req = 2'($urandom); req_tiles_0 = 8'($urandom); req_tiles_1 = 8'($urandom);
      cal_force = 1'($urandom);
      step();
      chk("reset_outputs", outs(), 0);
    end
    chk("reset_grant", int'(grant), 0);
    req = 2'b00; cal_force = 1'b0; sys_rst = 1'b0;
    step(); step();
    chk("idle_no_req", outs(), 0);

    // 2: single job, 3 tiles
    clear_log(); cal_delay = 2; req_tiles_0 = 8'd3; req = 2'b01; rc = cyc;
    wait_done(1, 200, "single_done_seen");
    req = 2'b00;
    chk("single_starts", n_start, 3);
    chk("single_idx0", start_idx[0], 0);
    chk("single_idx1", start_idx[1], 1);
    chk("single_idx2", start_idx[2], 2);
    chk("single_drains", n_drain, 9);
    chk("single_done", done_hist[0], 1);
    chk("single_err", err_hist[0], 0);
    chk("single_grant", grant_hist[0], 1);
    chk("single_grant_lat", grant_cyc[0] - rc, 1);
    chk("single_job_len", done_cyc[0] - grant_cyc[0], 18);
    chk("single_busy_at_done", done_busy[0], 1);
    step();
    chk("single_release", int'({grant, busy}), 0);

    // 3: contention from reset
    sys_rst = 1'b1; step(); step(); sys_rst = 1'b0;
    clear_log(); req_tiles_0 = 8'd1; req_tiles_1 = 8'd1; req = 2'b11;
    wait_done(1, 100, "cont_first_seen");
    req = 2'b10;
    wait_done(2, 100, "cont_second_seen");
    req = 2'b00;
    chk("cont_grant0", grant_hist[0], 1);
    chk("cont_done0", done_hist[0], 1);
    chk("cont_grant1", grant_hist[1], 2);
    chk("cont_done1", done_hist[1], 2);
    chk("cont_idle_gap", grant_cyc[1] - done_cyc[0], 2);
    chk("cont_starts", n_start, 2);

    // 4: timeout
    step();
    clear_log(); cal_delay = 0; req_tiles_1 = 8'd2; req = 2'b10;
    wait_done(1, 300, "timeout_seen");
    req = 2'b00;
    chk("timeout_done", done_hist[0], 2);
    chk("timeout_err", err_hist[0], 1);
    chk("timeout_lat", done_cyc[0] - last_start_cyc, 64);
    chk("timeout_starts", n_start, 1);
    chk("timeout_drains", n_drain, 0);

    // 5a: zero-tile job
    step();
    clear_log(); req_tiles_0 = 8'd0; req = 2'b01; rc = cyc;
    wait_done(1, 50, "zero_seen");
    req = 2'b00;
    chk("zero_done", done_hist[0], 1);
    chk("zero_lat", done_cyc[0] - rc, 1);
    chk("zero_starts", n_start, 0);
    chk("zero_err", err_hist[0], 0);

    // 5b: completion in the expiry cycle
    step();
    clear_log(); cal_delay = 63; req_tiles_0 = 8'd1; req = 2'b01;
    wait_done(1, 300, "tie_seen");
    req = 2'b00;
    chk("tie_err", err_hist[0], 0);
    chk("tie_drains", n_drain, 3);
    chk("tie_done", done_hist[0], 1);
    chk("tie_lat", done_cyc[0] - last_start_cyc, 67);

    // 5c: stray completion pulses during drain
    step();
    clear_log(); cal_delay = 2; stray_en = 1; req_tiles_1 = 8'd2; req = 2'b10;
    wait_done(1, 200, "stray_seen");
    req = 2'b00; stray_en = 0;
    chk("stray_starts", n_start, 2);
    chk("stray_drains", n_drain, 6);
    chk("stray_err", err_hist[0], 0);
    chk("stray_done", done_hist[0], 2);
    chk("stray_job_len", done_cyc[0] - grant_cyc[0], 12);

    // 6: reset during drain of tile 1 of 4
    step();
    clear_log(); req_tiles_0 = 8'd4; req = 2'b01; found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      step();
      if (out_drain_en && tile_idx == 8'd1) found = 1;
    end
    chk("midrst_reached_drain", found, 1);
    sys_rst = 1'b1;
    step();
    chk("midrst_outputs", outs(), 0);
    sys_rst = 1'b0; req = 2'b00;
    for (int i = 0; i < 5; i++) step();
    chk("midrst_no_done", n_done, 0);
    clear_log(); req_tiles_0 = 8'd1; req = 2'b01;
    wait_done(1, 100, "midrst_regrant_seen");
    req = 2'b00;
    chk("midrst_regrant", grant_hist[0], 1);
    chk("midrst_done", done_hist[0], 1);
    chk("midrst_starts", n_start, 1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
